// File: rtl/voice_allocator.sv
// Polyphony scheduler: decodes start/stop/stop-all command words and assigns notes to voice slots.
// Optional feature macro VOICE_STEAL_EN: when defined, a start with all slots busy steals the oldest voice.
module voice_allocator #(
  parameter int NVOICES = 8,
  parameter int NOTE_W  = 7,
  parameter int VEL_W   = 8,
  parameter int AGE_W   = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [15:0]                 i_data,
  input  logic                        i_valid,
  output logic                        o_ready,
  output logic [NVOICES-1:0]          o_voice_active,
  output logic [NVOICES*NOTE_W-1:0]   o_voice_note,
  output logic [NVOICES*VEL_W-1:0]    o_voice_vel,
  output logic                        o_trig,
  output logic [$clog2(NVOICES)-1:0]  o_trig_idx,
  output logic                        o_overflow
);

  localparam int IDX_W = $clog2(NVOICES);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SCAN   = 2'd1;
  localparam logic [1:0] S_COMMIT = 2'd2;

  localparam logic [AGE_W-1:0]  AGE_MAX  = {AGE_W{1'b1}};
  localparam logic [NOTE_W-1:0] NOTE_ALL = {NOTE_W{1'b1}};

  logic [1:0]                state_q, state_d;
  logic [15:0]               cmd_q, cmd_d;
  logic [NVOICES-1:0]        active_q, active_d;
  logic [NVOICES*NOTE_W-1:0] note_q, note_d;
  logic [NVOICES*VEL_W-1:0]  vel_q, vel_d;
  logic [NVOICES*AGE_W-1:0]  age_q, age_d;
  logic                      match_found_q, match_found_d;
  logic [IDX_W-1:0]          match_idx_q, match_idx_d;
  logic                      free_found_q, free_found_d;
  logic [IDX_W-1:0]          free_idx_q, free_idx_d;
  logic                      trig_q, trig_d;
  logic [IDX_W-1:0]          trig_idx_q, trig_idx_d;
  logic                      ovf_q, ovf_d;

  logic                      scan_match_found;
  logic [IDX_W-1:0]          scan_match_idx;
  logic                      scan_free_found;
  logic [IDX_W-1:0]          scan_free_idx;

`ifdef VOICE_STEAL_EN
  logic [IDX_W-1:0]          oldest_idx_q, oldest_idx_d;
  logic [IDX_W-1:0]          scan_oldest_idx;
  logic [AGE_W-1:0]          scan_oldest_age;
`endif

  logic                      tgt_valid;
  logic [IDX_W-1:0]          tgt_idx;

  // Command word layout: {on/off, note, velocity}
  logic                      cmd_on;
  logic [NOTE_W-1:0]         cmd_note;
  logic [VEL_W-1:0]          cmd_vel;

  assign cmd_on   = cmd_q[15];
  assign cmd_note = cmd_q[8 +: NOTE_W];
  assign cmd_vel  = cmd_q[0 +: VEL_W];

  // Descending sweep so the lowest qualifying index wins every search, including age ties.
  always_comb begin
    scan_match_found = 1'b0;
    scan_match_idx   = '0;
    scan_free_found  = 1'b0;
    scan_free_idx    = '0;
`ifdef VOICE_STEAL_EN
    scan_oldest_idx  = '0;
    scan_oldest_age  = '0;
`endif
    for (int v = NVOICES - 1; v >= 0; v--) begin
      if (active_q[v] && (note_q[v*NOTE_W +: NOTE_W] == cmd_note)) begin
        scan_match_found = 1'b1;
        scan_match_idx   = IDX_W'(v);
      end
      if (!active_q[v]) begin
        scan_free_found = 1'b1;
        scan_free_idx   = IDX_W'(v);
      end
`ifdef VOICE_STEAL_EN
      if (active_q[v] && (age_q[v*AGE_W +: AGE_W] >= scan_oldest_age)) begin
        scan_oldest_age = age_q[v*AGE_W +: AGE_W];
        scan_oldest_idx = IDX_W'(v);
      end
`endif
    end
  end

  always_comb begin
    state_d       = state_q;
    cmd_d         = cmd_q;
    active_d      = active_q;
    note_d        = note_q;
    vel_d         = vel_q;
    age_d         = age_q;
    match_found_d = match_found_q;
    match_idx_d   = match_idx_q;
    free_found_d  = free_found_q;
    free_idx_d    = free_idx_q;
`ifdef VOICE_STEAL_EN
    oldest_idx_d  = oldest_idx_q;
`endif
    trig_d        = 1'b0;
    trig_idx_d    = '0;
    ovf_d         = 1'b0;
    tgt_valid     = 1'b0;
    tgt_idx       = '0;

    case (state_q)
      S_IDLE: begin
        if (i_valid) begin
          cmd_d   = i_data;
          state_d = S_SCAN;
        end
      end

      S_SCAN: begin
        match_found_d = scan_match_found;
        match_idx_d   = scan_match_idx;
        free_found_d  = scan_free_found;
        free_idx_d    = scan_free_idx;
`ifdef VOICE_STEAL_EN
        oldest_idx_d  = scan_oldest_idx;
`endif
        state_d       = S_COMMIT;
      end

      S_COMMIT: begin
        state_d = S_IDLE;
        if (cmd_on) begin
          if (cmd_note != NOTE_ALL) begin
            if (match_found_q) begin
              tgt_valid = 1'b1;
              tgt_idx   = match_idx_q;
            end else if (free_found_q) begin
              tgt_valid = 1'b1;
              tgt_idx   = free_idx_q;
            end else begin
`ifdef VOICE_STEAL_EN
              tgt_valid = 1'b1;
              tgt_idx   = oldest_idx_q;
`else
              ovf_d     = 1'b1;
`endif
            end
          end
        end else if (cmd_note == NOTE_ALL) begin
          active_d = '0;
          age_d    = '0;
        end else if (match_found_q) begin
          // Note and velocity stay in the table after release.
          for (int v = 0; v < NVOICES; v++) begin
            if (IDX_W'(v) == match_idx_q) begin
              active_d[v]                = 1'b0;
              age_d[v*AGE_W +: AGE_W]    = '0;
            end
          end
        end

        if (tgt_valid) begin
          for (int v = 0; v < NVOICES; v++) begin
            if (IDX_W'(v) == tgt_idx) begin
              active_d[v]                = 1'b1;
              note_d[v*NOTE_W +: NOTE_W] = cmd_note;
              vel_d[v*VEL_W +: VEL_W]    = cmd_vel;
              age_d[v*AGE_W +: AGE_W]    = '0;
            end else if (active_q[v] && (age_q[v*AGE_W +: AGE_W] != AGE_MAX)) begin
              age_d[v*AGE_W +: AGE_W]    = age_q[v*AGE_W +: AGE_W] + 1'b1;
            end
          end
          trig_d     = 1'b1;
          trig_idx_d = tgt_idx;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Reset clears the voice tables as well as control, so an aborted command leaves no trace.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      cmd_q         <= '0;
      active_q      <= '0;
      note_q        <= '0;
      vel_q         <= '0;
      age_q         <= '0;
      match_found_q <= 1'b0;
      match_idx_q   <= '0;
      free_found_q  <= 1'b0;
      free_idx_q    <= '0;
`ifdef VOICE_STEAL_EN
      oldest_idx_q  <= '0;
`endif
      trig_q        <= 1'b0;
      trig_idx_q    <= '0;
      ovf_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      cmd_q         <= cmd_d;
      active_q      <= active_d;
      note_q        <= note_d;
      vel_q         <= vel_d;
      age_q         <= age_d;
      match_found_q <= match_found_d;
      match_idx_q   <= match_idx_d;
      free_found_q  <= free_found_d;
      free_idx_q    <= free_idx_d;
`ifdef VOICE_STEAL_EN
      oldest_idx_q  <= oldest_idx_d;
`endif
      trig_q        <= trig_d;
      trig_idx_q    <= trig_idx_d;
      ovf_q         <= ovf_d;
    end
  end

  assign o_ready        = (state_q == S_IDLE);
  assign o_voice_active = active_q;
  assign o_voice_note   = note_q;
  assign o_voice_vel    = vel_q;
  assign o_trig         = trig_q;
  assign o_trig_idx     = trig_idx_q;
  assign o_overflow     = ovf_q;

endmodule

// File: tb/tb_voice_allocator.sv
// Bench for voice_allocator: directed vector table, multi-cycle corner sequences and a random run
// against an array-based reference model. Honours VOICE_STEAL_EN the same way as the design.
module tb_voice_allocator;

  localparam int NV = 8;
  localparam int NW = 7;
  localparam int VW = 8;
  localparam int AW = 4;
  localparam int IW = 3;

  logic               clk = 1'b0;
  logic               rst;
  logic [15:0]        i_data;
  logic               i_valid;
  logic               o_ready;
  logic [NV-1:0]      o_voice_active;
  logic [NV*NW-1:0]   o_voice_note;
  logic [NV*VW-1:0]   o_voice_vel;
  logic               o_trig;
  logic [IW-1:0]      o_trig_idx;
  logic               o_overflow;

  voice_allocator #(.NVOICES(NV), .NOTE_W(NW), .VEL_W(VW), .AGE_W(AW)) dut (
    .clk(clk), .rst(rst), .i_data(i_data), .i_valid(i_valid), .o_ready(o_ready),
    .o_voice_active(o_voice_active), .o_voice_note(o_voice_note), .o_voice_vel(o_voice_vel),
    .o_trig(o_trig), .o_trig_idx(o_trig_idx), .o_overflow(o_overflow)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  bit m_active[NV];
  int m_note[NV];
  int m_vel[NV];
  int m_age[NV];
  bit e_trig;
  bit e_ovf;
  int e_idx;

  typedef struct {
    logic [15:0] cmd;
    logic        trig;
    int          idx;
    logic        ovf;
    logic [7:0]  act;
    int          note0;
  } vec_t;

  vec_t vt[17];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function void model_reset();
    for (int v = 0; v < NV; v++) begin
      m_active[v] = 0; m_note[v] = 0; m_vel[v] = 0; m_age[v] = 0;
    end
  endfunction

  function void model_cmd(input logic [15:0] c);
    int n, vel, tgt, best;
    n = int'(c[14:8]);
    vel = int'(c[7:0]);
    e_trig = 0; e_ovf = 0; e_idx = 0; tgt = -1;
    if (c[15]) begin
      if (n != 127) begin
        for (int v = NV - 1; v >= 0; v--) if (m_active[v] && m_note[v] == n) tgt = v;
        if (tgt < 0) for (int v = NV - 1; v >= 0; v--) if (!m_active[v]) tgt = v;
        if (tgt < 0) begin
`ifdef VOICE_STEAL_EN
          best = -1;
          for (int v = 0; v < NV; v++) if (m_age[v] > best) begin best = m_age[v]; tgt = v; end
`else
          e_ovf = 1;
`endif
        end
        if (tgt >= 0) begin
          for (int v = 0; v < NV; v++)
            if (v != tgt && m_active[v] && m_age[v] < (1 << AW) - 1) m_age[v]++;
          m_active[tgt] = 1; m_note[tgt] = n; m_vel[tgt] = vel; m_age[tgt] = 0;
          e_trig = 1; e_idx = tgt;
        end
      end
    end else if (n == 127) begin
      for (int v = 0; v < NV; v++) begin m_active[v] = 0; m_age[v] = 0; end
    end else begin
      for (int v = NV - 1; v >= 0; v--) if (m_active[v] && m_note[v] == n) tgt = v;
      if (tgt >= 0) begin m_active[tgt] = 0; m_age[tgt] = 0; end
    end
  endfunction

  function logic [63:0] m_active_vec();
    logic [63:0] r = '0;
    for (int v = 0; v < NV; v++) r[v] = m_active[v];
    return r;
  endfunction

  function logic [63:0] m_note_vec();
    logic [63:0] r = '0;
    for (int v = 0; v < NV; v++) r[v*NW +: NW] = NW'(m_note[v]);
    return r;
  endfunction

  function logic [63:0] m_vel_vec();
    logic [63:0] r = '0;
    for (int v = 0; v < NV; v++) r[v*VW +: VW] = VW'(m_vel[v]);
    return r;
  endfunction

  task automatic check_tables(input string tag);
    chk({tag, "_active"}, 64'(o_voice_active), m_active_vec());
    chk({tag, "_notes"},  64'(o_voice_note),   m_note_vec());
    chk({tag, "_vels"},   64'(o_voice_vel),    m_vel_vec());
  endtask

  // Entered at a negedge with the DUT idle; returns at the negedge of T+3.
  task automatic run_cmd(input logic [15:0] c);
    chk("ready_idle", 64'(o_ready), 64'd1);
    model_cmd(c);
    i_valid = 1'b1;
    i_data  = c;
    @(posedge clk);
    @(negedge clk);
    i_valid = 1'b0;
    i_data  = 16'($urandom);
    chk("ready_t1", 64'(o_ready), 64'd0);
    @(negedge clk);
    chk("ready_t2", 64'(o_ready), 64'd0);
    chk("trig_t2",  64'(o_trig),  64'd0);
    @(negedge clk);
    chk("ready_t3", 64'(o_ready), 64'd1);
    chk("trig",     64'(o_trig), 64'(e_trig));
    chk("overflow", 64'(o_overflow), 64'(e_ovf));
    if (e_trig) chk("trig_idx", 64'(o_trig_idx), 64'(e_idx));
    check_tables("cmd");
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_ready"},  64'(o_ready), 64'd1);
    chk({tag, "_active"}, 64'(o_voice_active), 64'd0);
    chk({tag, "_notes"},  64'(o_voice_note), 64'd0);
    chk({tag, "_vels"},   64'(o_voice_vel), 64'd0);
    chk({tag, "_trig"},   64'(o_trig), 64'd0);
    chk({tag, "_idx"},    64'(o_trig_idx), 64'd0);
    chk({tag, "_ovf"},    64'(o_overflow), 64'd0);
  endtask

  initial begin
    int pool[12];
    logic [15:0] c;
    int n;
    pool = '{69, 40, 60, 77, 95, 26, 28, 29, 31, 98, 50, 0};

    vt[0]  = '{16'hC500, 1'b1, 0, 1'b0, 8'h01, 69};
    vt[1]  = '{16'h4500, 1'b0, 0, 1'b0, 8'h00, 69};
    vt[2]  = '{16'h4900, 1'b0, 0, 1'b0, 8'h00, 69};
    vt[3]  = '{16'h450F, 1'b0, 0, 1'b0, 8'h00, 69};
    vt[4]  = '{16'hC500, 1'b1, 0, 1'b0, 8'h01, 69};
    vt[5]  = '{16'hC57F, 1'b1, 0, 1'b0, 8'h01, 69};
    vt[6]  = '{16'hA840, 1'b1, 1, 1'b0, 8'h03, 69};
    vt[7]  = '{16'hBC40, 1'b1, 2, 1'b0, 8'h07, 69};
    vt[8]  = '{16'hCD40, 1'b1, 3, 1'b0, 8'h0F, 69};
    vt[9]  = '{16'hDF40, 1'b1, 4, 1'b0, 8'h1F, 69};
    vt[10] = '{16'h9A40, 1'b1, 5, 1'b0, 8'h3F, 69};
    vt[11] = '{16'h9C40, 1'b1, 6, 1'b0, 8'h7F, 69};
    vt[12] = '{16'h9D40, 1'b1, 7, 1'b0, 8'hFF, 69};
`ifdef VOICE_STEAL_EN
    vt[13] = '{16'h9F40, 1'b1, 0, 1'b0, 8'hFF, 31};
    vt[14] = '{16'h3C00, 1'b0, 0, 1'b0, 8'hFB, 31};
    vt[15] = '{16'hE240, 1'b1, 2, 1'b0, 8'hFF, 31};
    vt[16] = '{16'h7F00, 1'b0, 0, 1'b0, 8'h00, 31};
`else
    vt[13] = '{16'h9F40, 1'b0, 0, 1'b1, 8'hFF, 69};
    vt[14] = '{16'h3C00, 1'b0, 0, 1'b0, 8'hFB, 69};
    vt[15] = '{16'hE240, 1'b1, 2, 1'b0, 8'hFF, 69};
    vt[16] = '{16'h7F00, 1'b0, 0, 1'b0, 8'h00, 69};
`endif

    rst = 1'b1;
    i_valid = 1'b0;
    i_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_state("rst_held");
    rst = 1'b0;
    @(negedge clk);
    check_reset_state("rst_released");
    model_reset();

    for (int i = 0; i < 17; i++) begin
      run_cmd(vt[i].cmd);
      chk($sformatf("vec%0d_trig", i),   64'(o_trig), 64'(vt[i].trig));
      chk($sformatf("vec%0d_ovf", i),    64'(o_overflow), 64'(vt[i].ovf));
      chk($sformatf("vec%0d_active", i), 64'(o_voice_active), 64'(vt[i].act));
      chk($sformatf("vec%0d_note0", i),  64'(o_voice_note[NW-1:0]), 64'(vt[i].note0));
      if (vt[i].trig) chk($sformatf("vec%0d_idx", i), 64'(o_trig_idx), 64'(vt[i].idx));
    end

    // Reset during SCAN aborts the pending start.
    run_cmd(16'hA810);
    i_valid = 1'b1;
    i_data  = 16'hC520;
    @(posedge clk);
    @(negedge clk);
    i_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_reset_state("midrst");
    model_reset();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("midrst_no_trig", 64'(o_trig), 64'd0);
      chk("midrst_active",  64'(o_voice_active), 64'd0);
    end

    // A command offered while busy is dropped, not queued.
    model_cmd(16'hC533);
    i_valid = 1'b1;
    i_data  = 16'hC533;
    @(posedge clk);
    @(negedge clk);
    i_data  = 16'hB244;
    @(negedge clk);
    i_valid = 1'b0;
    @(negedge clk);
    chk("busy_trig", 64'(o_trig), 64'd1);
    chk("busy_idx",  64'(o_trig_idx), 64'd0);
    check_tables("busy");
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("busy_no_second_trig", 64'(o_trig), 64'd0);
      check_tables("busy_after");
    end

    for (int i = 0; i < 400; i++) begin
      n = ($urandom_range(0, 19) == 0) ? 127 : pool[$urandom_range(0, 11)];
      c = {($urandom_range(0, 3) != 0), 7'(n), 8'($urandom)};
      run_cmd(c);
      if ($urandom_range(0, 4) == 0) begin
        @(negedge clk);
        chk("idle_no_trig", 64'(o_trig), 64'd0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
